// File: rtl/bsg_tick_watchdog.sv
// bsg_tick_watchdog: tick-driven watchdog with a valid/ready expiry event
// and a saturating count of acknowledged expiries.
module bsg_tick_watchdog #(
    parameter int ticks_p        = 8,
    parameter int expire_width_p = 8,
    localparam int tick_width_lp = $clog2(ticks_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      tick_i,
    input  logic                      arm_i,
    input  logic                      kick_i,
    input  logic                      disarm_i,
    output logic                      v_o,
    input  logic                      ready_i,
    output logic                      armed_o,
    output logic [tick_width_lp-1:0]  tick_count_o,
    output logic [expire_width_p-1:0] expire_count_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    // Tick count value whose next tick causes expiry, and the value held while expired.
    localparam logic [tick_width_lp-1:0] last_tick_lp = tick_width_lp'(ticks_p - 1);
    localparam logic [tick_width_lp-1:0] full_tick_lp = tick_width_lp'(ticks_p);

    state_e                      state_q, state_d;
    logic [tick_width_lp-1:0]    tick_cnt_q, tick_cnt_d;
    logic [expire_width_p-1:0]   exp_cnt_q, exp_cnt_d;
    logic                        v_q, v_d;
    logic                        armed_q, armed_d;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        exp_cnt_d  = exp_cnt_q;

        unique case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                // disarm wins over a simultaneous arm
                if (arm_i && !disarm_i) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (disarm_i) begin
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                end else if (arm_i || kick_i) begin
                    // a tick arriving with a kick/re-arm is discarded
                    tick_cnt_d = '0;
                end else if (tick_i) begin
                    if (tick_cnt_q == last_tick_lp) begin
                        state_d    = EXPIRED;
                        tick_cnt_d = full_tick_lp;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            EXPIRED: begin
                // v_o is high in this state, so ready_i alone completes the handshake
                if (ready_i) begin
                    if (exp_cnt_q != '1) begin
                        exp_cnt_d = exp_cnt_q + 1'b1;
                    end
                    state_d    = disarm_i ? IDLE : ARMED;
                    tick_cnt_d = '0;
                end else if (disarm_i) begin
                    // event dropped without being counted
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
            end
        endcase

        // Outputs are registered from the next state so they track the state exactly.
        v_d     = (state_d == EXPIRED);
        armed_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            exp_cnt_q  <= '0;
            v_q        <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            exp_cnt_q  <= exp_cnt_d;
            v_q        <= v_d;
            armed_q    <= armed_d;
        end
    end

    assign v_o            = v_q;
    assign armed_o        = armed_q;
    assign tick_count_o   = tick_cnt_q;
    assign expire_count_o = exp_cnt_q;

endmodule

// File: tb/tb_bsg_tick_watchdog.sv
// Directed bench for bsg_tick_watchdog: a vector table against a ticks_p=4
// instance, plus a hand sequence on a ticks_p=1, 2-bit expiry counter instance.
module tb_bsg_tick_watchdog;

    logic clk = 1'b0;
    logic reset_i, tick_i, arm_i, kick_i, disarm_i, ready_i;

    logic       a_v, a_armed;
    logic [2:0] a_tc;
    logic [7:0] a_ec;

    logic       b_v, b_armed;
    logic [0:0] b_tc;
    logic [1:0] b_ec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bsg_tick_watchdog #(.ticks_p(4), .expire_width_p(8)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i), .arm_i(arm_i),
        .kick_i(kick_i), .disarm_i(disarm_i), .v_o(a_v), .ready_i(ready_i),
        .armed_o(a_armed), .tick_count_o(a_tc), .expire_count_o(a_ec)
    );

    bsg_tick_watchdog #(.ticks_p(1), .expire_width_p(2)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i), .arm_i(arm_i),
        .kick_i(kick_i), .disarm_i(disarm_i), .v_o(b_v), .ready_i(ready_i),
        .armed_o(b_armed), .tick_count_o(b_tc), .expire_count_o(b_ec)
    );

    typedef struct {
        logic       rst, tick, arm, kick, dis, rdy;
        logic       ev, ea;
        logic [2:0] etc;
        logic [7:0] eec;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, tick, arm, kick, dis, rdy,
                                input logic ev, ea, input int etc, eec);
        vec_t v;
        v.rst = rst; v.tick = tick; v.arm = arm; v.kick = kick; v.dis = dis; v.rdy = rdy;
        v.ev = ev; v.ea = ea; v.etc = 3'(etc); v.eec = 8'(eec);
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs at the falling edge, let one rising edge pass.
    task automatic drive(input logic rst, tick, arm, kick, dis, rdy);
        @(negedge clk);
        reset_i = rst; tick_i = tick; arm_i = arm; kick_i = kick; disarm_i = dis; ready_i = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_b(input string name, input logic ev, ea, input logic [0:0] etc,
                           input logic [1:0] eec);
        n_tests++;
        if (b_v !== ev || b_armed !== ea || b_tc !== etc || b_ec !== eec) begin
            n_fail++;
            $display("FAIL %s: got v=%b armed=%b tc=%0d ec=%0d, want v=%b armed=%b tc=%0d ec=%0d",
                     name, b_v, b_armed, b_tc, b_ec, ev, ea, etc, eec);
        end
    endtask

    initial begin
        reset_i = 1'b1; tick_i = 1'b0; arm_i = 1'b0; kick_i = 1'b0; disarm_i = 1'b0; ready_i = 1'b0;

        //   rst tk arm kk dis rdy | v  a  tc ec
        // reset and IDLE behaviour
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 1,   0, 0, 0, 0);   // tick/kick ignored in IDLE
        add(0, 0, 1, 0, 1, 0,   0, 0, 0, 0);   // arm+disarm: stay IDLE
        add(0, 0, 1, 0, 0, 0,   0, 1, 0, 0);
        // basic expiry, ticks 3 cycles apart
        add(0, 1, 0, 0, 0, 1,   0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1,   0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1,   0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 1,   0, 1, 2, 0);
        add(0, 0, 0, 0, 0, 1,   0, 1, 2, 0);
        add(0, 0, 0, 0, 0, 1,   0, 1, 2, 0);
        add(0, 1, 0, 0, 0, 1,   0, 1, 3, 0);
        add(0, 0, 0, 0, 0, 1,   0, 1, 3, 0);
        add(0, 0, 0, 0, 0, 1,   0, 1, 3, 0);
        add(0, 1, 0, 0, 0, 1,   1, 1, 4, 0);   // v rises one cycle after 4th tick
        add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1);   // handshake, auto re-arm
        // kick coincident with 4th tick
        add(0, 1, 0, 0, 0, 0,   0, 1, 1, 1);
        add(0, 1, 0, 0, 0, 0,   0, 1, 2, 1);
        add(0, 1, 0, 0, 0, 0,   0, 1, 3, 1);
        add(0, 1, 0, 1, 0, 0,   0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0,   0, 1, 1, 1);
        add(0, 1, 0, 0, 0, 0,   0, 1, 2, 1);
        add(0, 1, 0, 0, 0, 0,   0, 1, 3, 1);
        add(0, 1, 0, 0, 0, 0,   1, 1, 4, 1);
        // backpressure: ticks, kicks, arm ignored while EXPIRED
        add(0, 1, 0, 0, 0, 0,   1, 1, 4, 1);
        add(0, 0, 0, 1, 0, 0,   1, 1, 4, 1);
        add(0, 1, 1, 0, 0, 0,   1, 1, 4, 1);
        add(0, 1, 0, 1, 0, 0,   1, 1, 4, 1);
        add(0, 0, 0, 0, 0, 0,   1, 1, 4, 1);
        add(0, 1, 0, 0, 0, 0,   1, 1, 4, 1);
        add(0, 0, 1, 1, 0, 0,   1, 1, 4, 1);
        add(0, 1, 0, 0, 0, 0,   1, 1, 4, 1);
        add(0, 0, 0, 0, 0, 0,   1, 1, 4, 1);
        add(0, 1, 0, 1, 0, 0,   1, 1, 4, 1);
        add(0, 0, 0, 0, 0, 1,   0, 1, 0, 2);
        // re-arm and tick+arm discard inside ARMED
        add(0, 1, 0, 0, 0, 0,   0, 1, 1, 2);
        add(0, 0, 1, 0, 0, 0,   0, 1, 0, 2);
        add(0, 1, 1, 0, 0, 0,   0, 1, 0, 2);
        // disarm during EXPIRED without ready: event dropped
        add(0, 1, 0, 0, 0, 0,   0, 1, 1, 2);
        add(0, 1, 0, 0, 0, 0,   0, 1, 2, 2);
        add(0, 1, 0, 0, 0, 0,   0, 1, 3, 2);
        add(0, 1, 0, 0, 0, 0,   1, 1, 4, 2);
        add(0, 0, 0, 0, 1, 0,   0, 0, 0, 2);
        add(0, 1, 0, 0, 0, 0,   0, 0, 0, 2);
        // disarm during EXPIRED with ready: counted, then IDLE
        add(0, 0, 1, 0, 0, 0,   0, 1, 0, 2);
        add(0, 1, 0, 0, 0, 0,   0, 1, 1, 2);
        add(0, 1, 0, 0, 0, 0,   0, 1, 2, 2);
        add(0, 1, 0, 0, 0, 0,   0, 1, 3, 2);
        add(0, 1, 0, 0, 0, 0,   1, 1, 4, 2);
        add(0, 0, 0, 0, 1, 1,   0, 0, 0, 3);
        // disarm from ARMED
        add(0, 0, 1, 0, 0, 0,   0, 1, 0, 3);
        add(0, 1, 0, 0, 0, 0,   0, 1, 1, 3);
        add(0, 1, 0, 0, 1, 0,   0, 0, 0, 3);
        // reset while expired
        add(0, 0, 1, 0, 0, 0,   0, 1, 0, 3);
        add(0, 1, 0, 0, 0, 0,   0, 1, 1, 3);
        add(0, 1, 0, 0, 0, 0,   0, 1, 2, 3);
        add(0, 1, 0, 0, 0, 0,   0, 1, 3, 3);
        add(0, 1, 0, 0, 0, 0,   1, 1, 4, 3);
        add(1, 1, 1, 0, 0, 1,   0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,   0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0,   0, 1, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].tick, vecs[i].arm, vecs[i].kick, vecs[i].dis, vecs[i].rdy);
            n_tests++;
            if (a_v !== vecs[i].ev || a_armed !== vecs[i].ea ||
                a_tc !== vecs[i].etc || a_ec !== vecs[i].eec) begin
                n_fail++;
                $display("FAIL vec%0d: got v=%b armed=%b tc=%0d ec=%0d, want v=%b armed=%b tc=%0d ec=%0d",
                         i, a_v, a_armed, a_tc, a_ec,
                         vecs[i].ev, vecs[i].ea, vecs[i].etc, vecs[i].eec);
            end
        end

        // ticks_p=1 with a 2-bit expiry counter: every tick expires, counter saturates at 3.
        drive(1, 0, 0, 0, 0, 0);
        check_b("b_reset", 0, 0, 1'd0, 2'd0);
        drive(0, 0, 1, 0, 0, 1);
        check_b("b_arm", 0, 1, 1'd0, 2'd0);
        for (int k = 0; k < 5; k++) begin
            logic [1:0] want_ec;
            want_ec = (k >= 2) ? 2'd3 : 2'(k + 1);
            drive(0, 1, 0, 0, 0, 1);
            check_b($sformatf("b_expire%0d", k), 1, 1, 1'd1, (k >= 3) ? 2'd3 : 2'(k));
            drive(0, 0, 0, 0, 0, 1);
            check_b($sformatf("b_ack%0d", k), 0, 1, 1'd0, want_ec);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_tick_watchdog.md
Name: bsg_tick_watchdog

Overview:
Watchdog timer that consumes the single-cycle overflow pulse from the upstream enabled overflow counter as its time base ("tick"). Once armed, it counts ticks and raises a valid/ready expiry event if ticks_p ticks pass without a kick. Sits directly downstream of the prescaling counter, one tick per counter wrap. Keeps a saturating count of acknowledged expiries for status readout.

Parameters:
ticks_p, 8, ticks without a kick before expiry; legal range >= 1
tick_width_lp, $clog2(ticks_p+1), derived width of the tick counter; not overridable
expire_width_p, 8, width of the saturating expiry counter

Ports:
clk_i  input  1  clock
reset_i  input  1  reset; synchronous, active-high
tick_i  input  1  time-base pulse, driven from the upstream counter's overflow output; one tick per cycle high
arm_i  input  1  arm, or restart if already armed
kick_i  input  1  service the watchdog; clears the tick count
disarm_i  input  1  return to idle
v_o  output  1  expiry event valid
ready_i  input  1  consumer accepts the expiry event
armed_o  output  1  high in ARMED or EXPIRED
tick_count_o  output  tick_width_lp  ticks seen since the last arm, kick or re-arm
expire_count_o  output  expire_width_p  acknowledged expiries, saturating

Behaviour:
- Reset (synchronous, active-high): state IDLE, tick_count_o=0, expire_count_o=0, v_o=0, armed_o=0. Reset overrides all inputs, including in the middle of an EXPIRED handshake.
- All outputs are registered. The state machine has three states: IDLE, ARMED, EXPIRED.
- IDLE:
  - tick_i and kick_i are ignored.
  - arm_i -> ARMED with tick count 0.
  - arm_i and disarm_i in the same cycle -> stay IDLE (disarm wins).
- ARMED, input priority disarm_i > arm_i/kick_i > tick_i:
  - disarm_i -> IDLE, tick count 0.
  - arm_i or kick_i -> tick count 0. A tick in the same cycle is discarded.
  - Otherwise tick_i increments the tick count.
  - tick_i with tick count == ticks_p-1 and no kick/arm/disarm -> EXPIRED, tick count = ticks_p, v_o=1 in the next cycle.
  - Latency: v_o rises exactly one cycle after the expiring tick.
  - ticks_p=1: the first tick after arming expires.
- EXPIRED:
  - v_o=1, held stable until handshake. tick_i, kick_i and arm_i are ignored; the tick count holds at ticks_p.
  - Handshake (v_o & ready_i): expire_count_o increments by 1 in the next cycle. At all-ones it saturates and holds.
  - After handshake: automatic re-arm -> ARMED, tick count 0, v_o=0 the next cycle.
  - disarm_i in a handshake cycle -> IDLE instead of re-arming. The expiry counter still increments.
  - disarm_i without ready_i -> IDLE, v_o drops, event dropped, expiry counter unchanged.
- ready_i is don't-care whenever v_o=0. v_o never depends combinationally on ready_i.
- Width rules:
  - The tick count never exceeds ticks_p; there is no wrap.
  - The expiry counter never wraps.

Test Plan:
- Basic expiry: ticks_p=4, reset, arm_i, 4 tick pulses spaced 3 cycles apart, ready_i=1 -> tick_count_o steps 1,2,3,4; v_o high exactly 1 cycle after the 4th tick, for one cycle; expire_count_o=1; back in ARMED with tick_count_o=0.
- Kick: ticks_p=4, arm_i, 3 ticks, then kick_i in the same cycle as the 4th tick -> tick_count_o=0, v_o stays 0; 4 more ticks -> v_o=1.
- Backpressure: expiry with ready_i=0 for 10 cycles while ticks and kicks arrive -> v_o held high, tick_count_o=4, expire_count_o=0; ready_i=1 -> expire_count_o=1 next cycle.
- Disarm during EXPIRED: disarm_i with ready_i=0 -> IDLE, v_o=0, armed_o=0, expire_count_o unchanged. Repeat with ready_i=1 -> IDLE and expire_count_o incremented.
- Saturation and ticks_p=1: expire_width_p=2, ticks_p=1, ready_i=1, 5 ticks -> 5 expiries, each with v_o high 1 cycle after its tick; expire_count_o reads 1,2,3,3,3.
- Reset mid-operation: assert reset_i while v_o=1 and expire_count_o=2 -> next cycle all outputs 0, state IDLE; ticks ignored until arm_i.
